// File: rtl/dft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// dft_frame_ctrl
//   Frame sequencer wrapped around a purely combinational N-point DFT core.
//   Collects N complex samples from a valid/ready stream into a frame buffer,
//   holds the buffer on the core inputs for CORE_LAT settle cycles, captures
//   all N core results on the last settle edge, then streams the bins out in
//   order on a valid/ready stream. Exactly one frame is in flight at a time.
//
// Ports
//   clk_i                  rising-edge clock
//   rst_n_i                synchronous active-low reset (also gates s_ready_o)
//   s_valid_i/s_ready_o    input sample handshake
//   s_re_i/s_im_i          signed W+1 bit sample parts
//   s_last_i               final sample of a frame
//   core_x_re_o/_im_o      buffered frame to the core, sample j at [j*(W+1) +: W+1]
//   core_X_re_i/_im_i      core results, bin k at [k*(W+N) +: W+N]
//   m_valid_o/m_ready_i    output bin handshake
//   m_re_o/m_im_o          W+N bit bin parts, passed through unmodified
//   m_last_o               high with bin N-1
//   m_idx_o                index of the bin currently presented
//   busy_o                 frame partially loaded or in flight
//   frame_err_o            one-cycle pulse on a malformed frame
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// dft_frame_lane
//   One sample slot of the frame buffer plus the matching result register.
//   Lane j stores input sample j and captures core bin j.
//
// Ports
//   clk_i, rst_n_i         clock, synchronous active-low reset
//   wr_en_i                load wr_re_i/wr_im_i into the sample slot
//   cap_en_i               capture X_re_i/X_im_i into the result slot
//   x_re_o/x_im_o          stored sample (drives the core input)
//   res_re_o/res_im_o      captured result
// ---------------------------------------------------------------------------
module dft_frame_lane #(
    parameter int SW = 16,
    parameter int RW = 23
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          wr_en_i,
    input  logic [SW-1:0] wr_re_i,
    input  logic [SW-1:0] wr_im_i,
    input  logic          cap_en_i,
    input  logic [RW-1:0] X_re_i,
    input  logic [RW-1:0] X_im_i,
    output logic [SW-1:0] x_re_o,
    output logic [SW-1:0] x_im_o,
    output logic [RW-1:0] res_re_o,
    output logic [RW-1:0] res_im_o
);

    logic [SW-1:0] x_re_q, x_im_q;
    logic [RW-1:0] res_re_q, res_im_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            x_re_q   <= '0;
            x_im_q   <= '0;
            res_re_q <= '0;
            res_im_q <= '0;
        end else begin
            if (wr_en_i) begin
                x_re_q <= wr_re_i;
                x_im_q <= wr_im_i;
            end
            if (cap_en_i) begin
                res_re_q <= X_re_i;
                res_im_q <= X_im_i;
            end
        end
    end

    assign x_re_o   = x_re_q;
    assign x_im_o   = x_im_q;
    assign res_re_o = res_re_q;
    assign res_im_o = res_im_q;

endmodule

module dft_frame_ctrl #(
    parameter int N        = 8,
    parameter int W        = 15,
    parameter int CORE_LAT = 1,
    localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [W:0]          s_re_i,
    input  logic [W:0]          s_im_i,
    input  logic                s_last_i,
    output logic [N*(W+1)-1:0]  core_x_re_o,
    output logic [N*(W+1)-1:0]  core_x_im_o,
    input  logic [N*(W+N)-1:0]  core_X_re_i,
    input  logic [N*(W+N)-1:0]  core_X_im_i,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [W+N-1:0]      m_re_o,
    output logic [W+N-1:0]      m_im_o,
    output logic                m_last_o,
    output logic [IW-1:0]       m_idx_o,
    output logic                busy_o,
    output logic                frame_err_o
);

    localparam int SW = W + 1;
    localparam int RW = W + N;
    localparam int LW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   cnt_q;
    logic [LW-1:0]   lat_q;
    logic [IW-1:0]   m_idx_q;
    logic            m_valid_q;
    logic            frame_err_q;

    logic [N-1:0][SW-1:0] buf_re, buf_im;
    logic [N-1:0][RW-1:0] res_re, res_im;

    logic s_fire;
    logic lat_last;
    logic cap_en;
    logic cnt_full;

    // Ready is gated by reset directly so a frame cannot be accepted while
    // reset is asserted, whatever state the registers still hold.
    assign s_ready_o = rst_n_i && (state_q == LOAD);
    assign s_fire    = s_valid_i && s_ready_o;
    assign cnt_full  = (cnt_q == IW'(N - 1));
    assign lat_last  = (lat_q == LW'(CORE_LAT - 1));
    // The core has had CORE_LAT full cycles on stable inputs at this edge.
    assign cap_en    = (state_q == COMPUTE) && lat_last;

    for (genvar j = 0; j < N; j++) begin : g_lane
        dft_frame_lane #(
            .SW(SW),
            .RW(RW)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .wr_en_i  (s_fire && (cnt_q == IW'(j))),
            .wr_re_i  (s_re_i),
            .wr_im_i  (s_im_i),
            .cap_en_i (cap_en),
            .X_re_i   (core_X_re_i[j*RW +: RW]),
            .X_im_i   (core_X_im_i[j*RW +: RW]),
            .x_re_o   (buf_re[j]),
            .x_im_o   (buf_im[j]),
            .res_re_o (res_re[j]),
            .res_im_o (res_im[j])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            lat_q       <= '0;
            m_idx_q     <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (s_fire) begin
                        if (cnt_full) begin
                            // Full frame; a missing s_last is flagged but
                            // the frame is still processed.
                            state_q     <= COMPUTE;
                            cnt_q       <= '0;
                            lat_q       <= '0;
                            frame_err_q <= !s_last_i;
                        end else if (s_last_i) begin
                            // Short frame: drop it. The partial buffer is
                            // fully overwritten by the next complete frame.
                            cnt_q       <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (lat_last) begin
                        state_q   <= UNLOAD;
                        lat_q     <= '0;
                        m_idx_q   <= '0;
                        m_valid_q <= 1'b1;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (m_ready_i) begin
                        if (m_idx_q == IW'(N - 1)) begin
                            state_q   <= LOAD;
                            m_idx_q   <= '0;
                            m_valid_q <= 1'b0;
                        end else begin
                            m_idx_q <= m_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= LOAD;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign core_x_re_o = buf_re;
    assign core_x_im_o = buf_im;

    // Bin data is a mux over registers indexed by a register, so it holds
    // stable for as long as the handshake is stalled.
    assign m_valid_o   = m_valid_q;
    assign m_re_o      = res_re[m_idx_q];
    assign m_im_o      = res_im[m_idx_q];
    assign m_idx_o     = m_idx_q;
    assign m_last_o    = m_valid_q && (m_idx_q == IW'(N - 1));
    assign busy_o      = (state_q != LOAD) || (cnt_q != '0);
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_dft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dft_frame_ctrl
//   Bench for dft_frame_ctrl with a floating-point DFT standing in for the
//   combinational core. A frame-level model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_dft_frame_ctrl;

    localparam int N  = 8;
    localparam int W  = 15;
    localparam int CL = 1;
    localparam int SW = W + 1;
    localparam int RW = W + N;
    localparam real PI = 3.14159265358979323846;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [SW-1:0]       s_re = '0, s_im = '0;
    logic                s_last = 1'b0;
    logic [N*SW-1:0]     core_x_re, core_x_im;
    logic [N*RW-1:0]     core_X_re, core_X_im;
    logic                m_valid;
    logic                m_ready = 1'b1;
    logic [RW-1:0]       m_re, m_im;
    logic                m_last;
    logic [2:0]          m_idx;
    logic                busy;
    logic                frame_err;

    always #5 clk = ~clk;

    dft_frame_ctrl #(.N(N), .W(W), .CORE_LAT(CL)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_valid_i(s_valid), .s_ready_o(s_ready),
        .s_re_i(s_re), .s_im_i(s_im), .s_last_i(s_last),
        .core_x_re_o(core_x_re), .core_x_im_o(core_x_im),
        .core_X_re_i(core_X_re), .core_X_im_i(core_X_im),
        .m_valid_o(m_valid), .m_ready_i(m_ready),
        .m_re_o(m_re), .m_im_o(m_im), .m_last_o(m_last), .m_idx_o(m_idx),
        .busy_o(busy), .frame_err_o(frame_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---- reference DFT: X_k = sum_j x_j * exp(-2*pi*i*j*k/N), rounded ----
    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic int dft_bin(input int xr[N], input int xi[N], input int k, input bit want_im);
        real acc = 0.0;
        for (int j = 0; j < N; j++) begin
            real a, c, s;
            a = 2.0 * PI * real'(j * k) / real'(N);
            c = $cos(a);
            s = $sin(a);
            if (!want_im) acc = acc + real'(xr[j]) * c + real'(xi[j]) * s;
            else          acc = acc + real'(xi[j]) * c - real'(xr[j]) * s;
        end
        return rnd(acc);
    endfunction

    // ---- stand-in for the combinational core ----
    always @* begin : core_model
        int xr[N];
        int xi[N];
        for (int j = 0; j < N; j++) begin
            xr[j] = int'($signed(core_x_re[j*SW +: SW]));
            xi[j] = int'($signed(core_x_im[j*SW +: SW]));
        end
        for (int k = 0; k < N; k++) begin
            core_X_re[k*RW +: RW] = RW'(dft_bin(xr, xi, k, 1'b0));
            core_X_im[k*RW +: RW] = RW'(dft_bin(xr, xi, k, 1'b1));
        end
    end

    // ---- frame-level model ----
    int  md_nload = 0;      // samples gathered toward the current frame
    int  md_settle = 0;     // settle cycles left before results are out
    bit  md_unl = 1'b0;     // bins are being presented
    int  md_idx = 0;        // next bin to present
    bit  md_err = 1'b0;
    int  fr_re[N], fr_im[N];
    int  ex_re[N], ex_im[N];

    always @(posedge clk) begin
        if (!rst_n) begin
            md_nload = 0; md_settle = 0; md_unl = 1'b0; md_idx = 0; md_err = 1'b0;
        end else begin
            md_err = 1'b0;
            if (md_settle > 0) begin
                md_settle--;
                if (md_settle == 0) begin md_unl = 1'b1; md_idx = 0; end
            end else if (md_unl) begin
                if (m_ready) begin
                    if (md_idx == N - 1) begin md_unl = 1'b0; md_idx = 0; end
                    else md_idx++;
                end
            end else if (s_valid) begin
                fr_re[md_nload] = int'($signed(s_re));
                fr_im[md_nload] = int'($signed(s_im));
                if (md_nload == N - 1) begin
                    for (int k = 0; k < N; k++) begin
                        ex_re[k] = dft_bin(fr_re, fr_im, k, 1'b0);
                        ex_im[k] = dft_bin(fr_re, fr_im, k, 1'b1);
                    end
                    md_settle = CL;
                    md_nload  = 0;
                    md_err    = !s_last;
                end else if (s_last) begin
                    md_nload = 0;
                    md_err   = 1'b1;
                end else begin
                    md_nload++;
                end
            end
        end
    end

    // ---- per-cycle compare and beat log ----
    typedef struct { int re; int im; int idx; bit last; } beat_t;
    beat_t got[$];
    bit    chk_en = 1'b0;
    int    nerr_seen = 0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("s_ready",   int'(s_ready),   int'(rst_n && md_settle == 0 && !md_unl));
            chk("m_valid",   int'(m_valid),   int'(md_unl));
            chk("m_last",    int'(m_last),    int'(md_unl && md_idx == N - 1));
            chk("m_idx",     int'(m_idx),     md_unl ? md_idx : 0);
            chk("busy",      int'(busy),      int'(md_settle > 0 || md_unl || md_nload != 0));
            chk("frame_err", int'(frame_err), int'(md_err));
            if (md_unl) begin
                chk("m_re", int'($signed(m_re)), ex_re[md_idx]);
                chk("m_im", int'($signed(m_im)), ex_im[md_idx]);
            end
            if (frame_err === 1'b1) nerr_seen++;
            if (m_valid === 1'b1 && m_ready === 1'b1)
                got.push_back('{int'($signed(m_re)), int'($signed(m_im)), int'(m_idx), m_last});
        end
    end

    // ---- m_ready pattern: 0 held high, 1 toggling, 2 random ----
    int rmode = 0;
    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---- stimulus helpers ----
    bit rnd_gap = 1'b0;

    task automatic send(input int re, input int im, input bit last);
        int t = 0;
        s_valid = 1'b1; s_re = SW'(re); s_im = SW'(im); s_last = last;
        forever begin
            @(negedge clk);
            if (s_ready === 1'b1) break;
            t++;
            if (t > 300) begin
                checks++; errors++;
                $display("FAIL send_timeout got=s_ready_low exp=accept at t=%0t", $time);
                s_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input int vre[N], input int vim[N], input int len, input bit with_last);
        for (int i = 0; i < len; i++) begin
            if (rnd_gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(vre[i], vim[i], with_last && (i == len - 1));
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy !== 1'b0 || m_valid !== 1'b0) && t < 400);
        if (t >= 400) begin
            checks++; errors++;
            $display("FAIL idle_timeout got=busy exp=idle at t=%0t", $time);
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_impulse_bins(input string nm);
        chk({nm, "_beats"}, got.size(), N);
        for (int k = 0; k < got.size() && k < N; k++) begin
            chk({nm, "_re"},   got[k].re, 100);
            chk({nm, "_im"},   got[k].im, 0);
            chk({nm, "_idx"},  got[k].idx, k);
            chk({nm, "_last"}, int'(got[k].last), int'(k == N - 1));
        end
    endtask

    int imp_re[N], imp_im[N], dc_re[N], dc_im[N], r_re[N], r_im[N];
    int e0;

    initial begin
        for (int i = 0; i < N; i++) begin
            imp_re[i] = (i == 0) ? 100 : 0; imp_im[i] = 0;
            dc_re[i]  = 10;                 dc_im[i]  = 0;
        end

        // reset state
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_busy",    int'(busy),    0);
        chk("rst_err",     int'(frame_err), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: impulse, plus literal first-valid latency
        got.delete();
        send_frame(imp_re, imp_im, N, 1'b1);
        @(negedge clk); chk("t1_lat_m_valid_early", int'(m_valid), 0);
        @(negedge clk); chk("t1_lat_m_valid",       int'(m_valid), 1);
        wait_idle();
        chk_impulse_bins("t1");

        // 2: DC frame
        got.delete();
        send_frame(dc_re, dc_im, N, 1'b1);
        wait_idle();
        chk("t2_beats", got.size(), N);
        if (got.size() == N) begin
            chk("t2_bin0_re", got[0].re, 80);
            chk("t2_bin0_im", got[0].im, 0);
            for (int k = 1; k < N; k++) begin
                chk("t2_bin_re_small", int'(got[k].re >= -1 && got[k].re <= 1), 1);
                chk("t2_bin_im_small", int'(got[k].im >= -1 && got[k].im <= 1), 1);
            end
        end

        // 3: impulse with toggling m_ready
        got.delete();
        rmode = 1;
        send_frame(imp_re, imp_im, N, 1'b1);
        wait_idle();
        chk_impulse_bins("t3");
        rmode = 0;

        // 4: short frame then a good impulse frame
        got.delete();
        e0 = nerr_seen;
        send_frame(imp_re, imp_im, 3, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_err_pulses", nerr_seen - e0, 1);
        chk("t4_no_output",  got.size(), 0);
        send_frame(imp_re, imp_im, N, 1'b1);
        wait_idle();
        chk_impulse_bins("t4");

        // 5: full frame without s_last
        got.delete();
        e0 = nerr_seen;
        send_frame(imp_re, imp_im, N, 1'b0);
        wait_idle();
        chk("t5_err_pulses", nerr_seen - e0, 1);
        chk_impulse_bins("t5");

        // 6: reset right after bin 3 handshake
        got.delete();
        send_frame(imp_re, imp_im, N, 1'b1);
        begin
            int t = 0;
            do begin @(negedge clk); t++; end
            while (!(m_valid === 1'b1 && m_idx == 3'd3) && t < 100);
            chk("t6_reached_bin3", int'(t < 100), 1);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_s_ready", int'(s_ready), 1);
        chk("t6_m_valid", int'(m_valid), 0);
        chk("t6_busy",    int'(busy),    0);
        @(posedge clk); #1;
        got.delete();
        send_frame(dc_re, dc_im, N, 1'b1);
        wait_idle();
        chk("t6_beats", got.size(), N);
        if (got.size() == N) chk("t6_bin0_re", got[0].re, 80);

        // randomized frames: random data, gaps, backpressure, malformed frames
        rmode = 2;
        rnd_gap = 1'b1;
        for (int f = 0; f < 16; f++) begin
            int kind;
            kind = int'($urandom_range(0, 5));
            for (int i = 0; i < N; i++) begin
                r_re[i] = int'($signed(16'($urandom)));
                r_im[i] = int'($signed(16'($urandom)));
            end
            if (kind == 0)      send_frame(r_re, r_im, int'($urandom_range(1, N - 1)), 1'b1);
            else if (kind == 1) send_frame(r_re, r_im, N, 1'b0);
            else                send_frame(r_re, r_im, N, 1'b1);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
